// File: rtl/fpu_divide_iterate.sv
// Restoring-division core of the float divide path: resolves 27 quotient bits,
// STEPS_PER_CYCLE per clock, between the exponent stage and normalize/round.
package fpu_div_pkg;
  typedef struct packed {
    logic        valid;
    logic        sign;
    logic [50:0] a;
    logic [50:0] b;
    logic [26:0] y;
    logic        nan;
    logic        inf;
    logic        zero;
    logic [9:0]  exponent;
    logic        exp_neg;
    logic [1:0]  mode;
  } fpu_div_result_t;
endpackage

module fpu_divide_iterate
  import fpu_div_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  fpu_div_result_t in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output fpu_div_result_t out_data,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  localparam int ITERATIONS = 27 / STEPS_PER_CYCLE;
  localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(ITERATIONS - 1);

  if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 3 ||
        STEPS_PER_CYCLE == 9 || STEPS_PER_CYCLE == 27)) begin : g_bad_steps
    $error("fpu_divide_iterate: STEPS_PER_CYCLE must be 1, 3, 9 or 27");
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid and data are held until that edge, ready never waits on valid.
  typedef enum logic [1:0] {IDLE = 2'd0, ITERATE = 2'd1, DONE = 2'd2} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  fpu_div_result_t work;

  logic [50:0] a_n;
  logic [50:0] b_n;
  logic [26:0] y_n;

  // Quotient bits arrive MSB first; shifting them in leaves y aligned after 27 steps.
  always_comb begin
    a_n = work.a;
    b_n = work.b;
    y_n = work.y;
    for (int k = 0; k < STEPS_PER_CYCLE; k++) begin
      if (b_n <= a_n) begin
        a_n = a_n - b_n;
        y_n = {y_n[25:0], 1'b1};
      end else begin
        y_n = {y_n[25:0], 1'b0};
      end
      b_n = b_n >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work       <= in_data;
            work.y     <= '0;
            work.valid <= 1'b1;
            cnt        <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            if (in_data.nan | in_data.inf | in_data.zero) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= ITERATE;
            end
          end
        end
        ITERATE: begin
          work.a <= a_n;
          work.b <= b_n;
          work.y <= y_n;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_CNT) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = work;
  assign dbg_state = state;

endmodule

// File: tb/tb_fpu_divide_iterate.sv
// Directed bench for fpu_divide_iterate: four instances (1, 3, 9, 27 steps per
// clock) checked against hand-computed vectors and a bit-serial reference.
module tb_fpu_divide_iterate;
  import fpu_div_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid  [4];
  logic            in_ready  [4];
  fpu_div_result_t in_data   [4];
  logic            out_valid [4];
  logic            out_ready [4];
  fpu_div_result_t out_data  [4];
  logic            busy      [4];
  logic [1:0]      dbg_state [4];

  int n_checks = 0;
  int n_passed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    fpu_divide_iterate #(
      .STEPS_PER_CYCLE(g == 0 ? 1 : g == 1 ? 3 : g == 2 ? 9 : 27)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g]),
      .dbg_state (dbg_state[g])
    );
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs === exp) n_passed++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic int spc_of(input int u);
    return (u == 0) ? 1 : (u == 1) ? 3 : (u == 2) ? 9 : 27;
  endfunction

  function automatic fpu_div_result_t mk(input logic [23:0] ma, input logic [23:0] mb,
                                         input logic sgn, input logic [9:0] ex,
                                         input logic nan);
    fpu_div_result_t d;
    d          = '0;
    d.a        = 51'(ma) << 26;
    d.b        = 51'(mb) << 26;
    d.sign     = sgn;
    d.exponent = ex;
    d.nan      = nan;
    d.mode     = 2'b01;
    d.y        = 27'h5A5A5A5;
    return d;
  endfunction

  // Bit-serial restoring division, one quotient bit per step.
  function automatic fpu_div_result_t ref_div(input fpu_div_result_t d);
    fpu_div_result_t r;
    r       = d;
    r.valid = 1'b1;
    r.y     = '0;
    if (!(d.nan | d.inf | d.zero)) begin
      for (int i = 0; i < 27; i++) begin
        if (r.b <= r.a) begin
          r.a        = r.a - r.b;
          r.y[26-i]  = 1'b1;
        end
        r.b = r.b >> 1;
      end
    end
    return r;
  endfunction

  // lat = rising edges after the accept edge until out_valid is seen high.
  task automatic run_op(input int u, input fpu_div_result_t d,
                        output fpu_div_result_t r, output int lat);
    int w;
    w = 0;
    while (!in_ready[u] && w < 100) begin
      @(posedge clk); #1; w++;
    end
    check("in_ready_before_accept", 160'(in_ready[u]), 160'(1));
    in_data[u]  = d;
    in_valid[u] = 1'b1;
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
    in_data[u]  = '0;
    lat = 0;
    while (!out_valid[u] && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    r = out_data[u];
  endtask

  task automatic take(input int u);
    out_ready[u] = 1'b1;
    @(posedge clk); #1;
    out_ready[u] = 1'b0;
    check("out_valid_after_handshake", 160'(out_valid[u]), 160'(0));
    check("in_ready_after_handshake", 160'(in_ready[u]), 160'(1));
  endtask

  task automatic check_reset_values(input int u);
    check("rst_in_ready", 160'(in_ready[u]), 160'(1));
    check("rst_out_valid", 160'(out_valid[u]), 160'(0));
    check("rst_busy", 160'(busy[u]), 160'(0));
    check("rst_out_data", 160'(out_data[u]), 160'(0));
  endtask

  initial begin
    fpu_div_result_t d, r, e, held;
    int lat, cnt;

    for (int u = 0; u < 4; u++) begin
      in_valid[u]  = 1'b0;
      in_data[u]   = '0;
      out_ready[u] = 1'b0;
    end

    // Reset
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++) check_reset_values(u);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1.5 / 1.0
    d = mk(24'hC00000, 24'h800000, 1'b0, 10'd0, 1'b0);
    run_op(0, d, r, lat);
    check("div15_latency", 160'(lat), 160'(27));
    check("div15_y", 160'(r.y), 160'(27'h6000000));
    check("div15_a", 160'(r.a), 160'(0));
    check("div15_b", 160'(r.b), 160'(51'h400000));
    check("div15_valid_bit", 160'(r.valid), 160'(1));
    take(0);

    // 1.0 / 1.5
    d = mk(24'h800000, 24'hC00000, 1'b1, 10'h17F, 1'b0);
    run_op(0, d, r, lat);
    check("div23_y", 160'(r.y), 160'(27'h2AAAAAA));
    check("div23_a_nonzero", 160'(r.a != 51'd0), 160'(1));
    check("div23_sign", 160'(r.sign), 160'(1));
    check("div23_exponent", 160'(r.exponent), 160'(10'h17F));
    check("div23_mode", 160'(r.mode), 160'(2'b01));
    take(0);

    // Backpressure: result held, no accept while DONE
    d = mk(24'hC00000, 24'h800000, 1'b0, 10'd5, 1'b0);
    run_op(0, d, held, lat);
    in_data[0]  = mk(24'h900000, 24'h800000, 1'b0, 10'd0, 1'b0);
    in_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_out_data_stable", 160'(out_data[0]), 160'(held));
      check("bp_in_ready_low", 160'(in_ready[0]), 160'(0));
      check("bp_out_valid_high", 160'(out_valid[0]), 160'(1));
    end
    in_valid[0]  = 1'b0;
    in_data[0]   = '0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    check("bp_in_ready_after", 160'(in_ready[0]), 160'(1));
    check("bp_busy_after", 160'(busy[0]), 160'(0));

    // Special-case bypass: DONE immediately after the accept edge
    d = mk(24'h800000, 24'h000000, 1'b0, 10'd0, 1'b1);
    run_op(0, d, r, lat);
    check("bypass_latency", 160'(lat), 160'(0));
    check("bypass_busy", 160'(busy[0]), 160'(1));
    check("bypass_y", 160'(r.y), 160'(0));
    check("bypass_nan", 160'(r.nan), 160'(1));
    check("bypass_a", 160'(r.a), 160'(d.a));
    take(0);
    check("bypass_busy_after", 160'(busy[0]), 160'(0));

    // Reset mid-ITERATE
    in_data[0]  = mk(24'hC00000, 24'h800000, 1'b0, 10'd0, 1'b0);
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("pre_reset_busy", 160'(busy[0]), 160'(1));
    rst = 1'b0;
    #1;
    check_reset_values(0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_values(0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid[0]) cnt++;
    end
    check("aborted_no_out_valid", 160'(cnt), 160'(0));
    d = mk(24'hC00000, 24'h800000, 1'b0, 10'd0, 1'b0);
    run_op(0, d, r, lat);
    check("after_reset_latency", 160'(lat), 160'(27));
    check("after_reset_y", 160'(r.y), 160'(27'h6000000));
    take(0);

    // Parameter sweep against the reference model
    for (int u = 1; u < 4; u++) begin
      for (int n = 0; n < 1000; n++) begin
        d = mk(24'h800000 | 24'($urandom_range(0, 24'h7FFFFF)),
               24'h800000 | 24'($urandom_range(0, 24'h7FFFFF)),
               1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), 1'b0);
        e = ref_div(d);
        run_op(u, d, r, lat);
        check("sweep_latency", 160'(lat), 160'(27 / spc_of(u)));
        check("sweep_result", 160'(r), 160'(e));
        take(u);
      end
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/fpu_divide_iterate.md
Name: fpu_divide_iterate

Overview:
- Multi-cycle restoring-division core of the FPU float divide path.
- Sits between the exponent/special-case stage and the normalize/round stage.
- Accepts one fpu_div_result_t from the exponent stage, which carries the A and b mantissa operands pre-shifted left by 26.
- Runs 27 quotient-bit steps: compare/subtract remainder A against divisor b, then shift b right.
- Hands the finished quotient y and remainder A downstream under a valid/ready handshake.

Parameters:
- STEPS_PER_CYCLE, 1, quotient bits resolved per clock. Legal values: 1, 3, 9, 27; any other value is an elaboration error.
- ITERATIONS, 27/STEPS_PER_CYCLE, derived localparam: clocks spent in the ITERATE state.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- in_valid  input  1  upstream operand valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  fpu_div_result_t  exponent-stage result: sign, A, b, nan/inf/zero, exponent, exp_neg, mode. Incoming y is ignored.
- out_valid  output  1  quotient result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  fpu_div_result_t  in_data fields passed through, with final A, final b and computed y; valid bit forced to 1.
- busy  output  1  high in ITERATE or DONE.

Behaviour:
- States: IDLE, ITERATE, DONE. Encoding is free; reset state is IDLE.
- Reset values: in_ready=1, out_valid=0, busy=0, out_data=0, step counter=0.
- Reset may assert mid-ITERATE or mid-DONE. The operation is abandoned with no output, and the block is back in IDLE on deassertion.
- in_ready = (state==IDLE). It is combinational from state only and has no dependency on out_ready.
- out_valid = (state==DONE). out_data is held stable while out_valid=1 and out_ready=0.
- IDLE, on in_valid=1:
  - Latch in_data into the working register and clear y to 0.
  - Counter = 0.
  - If in_data.nan|inf|zero, go to DONE with y=0 and A, b as loaded (bypass).
  - Otherwise go to ITERATE.
- ITERATE, each clock, for STEPS_PER_CYCLE sequential sub-steps with global index i = counter*STEPS_PER_CYCLE + k:
  - If b <= A (51-bit unsigned): A = A - b and y[26-i] = 1; else y[26-i] = 0.
  - Then b = b >> 1 (logical, zero fill).
  - After the sub-steps, counter increments.
  - When counter == ITERATIONS-1 at the edge, go to DONE.
- Arithmetic rules:
  - A stays within 51 bits and never underflows, because subtraction is guarded by the compare.
  - exponent, exp_neg, sign, nan/inf/zero and mode are untouched through ITERATE.
- DONE:
  - out_ready=1 moves to IDLE on the next edge.
  - out_ready=0 holds DONE indefinitely.
  - A new operand is never accepted in the same cycle as the DONE handshake.
- Latency (normal path):
  - Accept edge T.
  - out_valid rises after the edge at T+ITERATIONS.
  - Earliest next accept is one cycle after the output handshake.
  - With STEPS_PER_CYCLE=1: 27 clocks from accept to out_valid; minimum initiation interval 29 clocks.
- Latency (bypass path): out_valid one clock after accept.
- The remainder sticky (A!=0) is not folded into y here; the normalize stage does it.
- Upstream must hold in_data stable while in_valid=1 and in_ready=0.

Test Plan:
- 1.5/1.0, normal path:
  - Stimulus: A=0xC00000<<26, b=0x800000<<26, flags 0, exponent=0, STEPS_PER_CYCLE=1.
  - Required: out_valid exactly 27 clocks after the accept edge; y=0x6000000; A=0; b=0x800000>>1 (27 right shifts of the loaded value).
- 1.0/1.5, repeating quotient:
  - Stimulus: A=0x800000<<26, b=0xC00000<<26.
  - Required: y=0x2AAAAAA, final A!=0, sign and exponent passed through unchanged.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 clocks after out_valid rises.
  - Required: out_data constant, in_ready=0 throughout; after out_ready=1, in_ready=1 on the next cycle.
- Special-case bypass:
  - Stimulus: in_data.nan=1 (b mantissa zero).
  - Required: out_valid one clock after accept, y=0, nan=1 propagated, no ITERATE cycles (busy high for exactly 1 cycle before the handshake).
- Reset mid-operation:
  - Stimulus: assert rst low at iteration 12, release, then issue the 1.5/1.0 case again.
  - Required: no out_valid from the aborted op; outputs at reset values during reset; correct y=0x6000000 afterwards.
- Parameter sweep:
  - Stimulus: STEPS_PER_CYCLE=3, 9, 27 with 1,000 random normalised operand pairs, checked against a 1-bit-per-step reference model.
  - Required: identical y and A results; latency 9, 3 and 1 clocks respectively.
